inst_fetch_queue: RTL and testbench

//  Instruction fetch queue directly upstream of Dispatch_Decoder. Generates the fetch PC, requests words from the

---
 rtl/inst_fetch_queue.sv | 102 ++++++++++
 tb/tb_inst_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues PC-ordered I-cache reads into a circular FIFO and presents the head
// instruction to the decoder. A jump at dispatch or a CDB mispredict redirects the PC and flushes the queue.
module inst_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          PTR_W    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Resetb,
   output logic        Icache_Rd,
   output logic [31:0] Icache_Addr,
   input  logic [31:0] Icache_Data,
   input  logic        Icache_Valid,
   output logic [31:0] Ifq_Inst,
   output logic [31:0] Ifq_Pc_Plus4,
   output logic        Ifq_Empty,
   input  logic        Dispatch_Ren,
   input  logic        Dispatch_Jmp,
   input  logic [31:0] Dispatch_Jmp_Addr,
   input  logic        Cdb_Flush,
   input  logic [31:0] Cdb_Branch_Addr
);

   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

   logic [31:0]      pc;
   logic [31:0]      req_addr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             inflight;
   logic             drop;

   logic [31:0] inst_mem [DEPTH];
   logic [31:0] pc4_mem  [DEPTH];

   logic             empty;
   logic             pop;
   logic             jmp_take;
   logic             redirect;
   logic             wr_en;
   logic [CNT_W:0]   occupancy;

   // A request reserves its slot up front, so occupancy counts the in-flight word too.
   assign empty     = (count == '0);
   assign pop       = Dispatch_Ren & ~empty;
   assign jmp_take  = Dispatch_Jmp & pop & ~Cdb_Flush;
   assign redirect  = Cdb_Flush | jmp_take;
   assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
   assign wr_en     = Icache_Valid & inflight & ~drop & ~redirect;

   assign Icache_Rd    = Resetb & (occupancy < DEPTH_V) & ~Cdb_Flush & ~Dispatch_Jmp;
   assign Icache_Addr  = pc;
   assign Ifq_Empty    = empty;
   assign Ifq_Inst     = empty ? 32'h0 : inst_mem[rd_ptr];
   assign Ifq_Pc_Plus4 = empty ? 32'h0 : pc4_mem[rd_ptr];

   always_ff @(posedge Clk) begin
      if (!Resetb) begin
         pc       <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else if (redirect) begin
         pc       <= Cdb_Flush ? Cdb_Branch_Addr : Dispatch_Jmp_Addr;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= 1'b0;
         // A return landing this cycle is already killed via wr_en; only a later one needs dropping.
         drop     <= inflight & ~Icache_Valid;
      end else begin
         inflight <= Icache_Rd;
         if (Icache_Rd)
            pc <= pc + 32'd4;
         if (Icache_Valid)
            drop <= 1'b0;
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Resetb && wr_en) begin
         inst_mem[wr_ptr] <= Icache_Data;
         pc4_mem[wr_ptr]  <= req_addr + 32'd4;
      end
      if (Icache_Rd)
         req_addr <= pc;
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: a one-cycle I-cache responder returning addr>>2 and a scoreboard of
// expected head entries, exercised by one task per scenario.
module tb_inst_fetch_queue;

   logic        Clk = 1'b0;
   logic        Resetb;
   logic        Icache_Rd;
   logic [31:0] Icache_Addr;
   logic [31:0] Icache_Data = 32'h0;
   logic        Icache_Valid = 1'b0;
   logic [31:0] Ifq_Inst;
   logic [31:0] Ifq_Pc_Plus4;
   logic        Ifq_Empty;
   logic        Dispatch_Ren;
   logic        Dispatch_Jmp;
   logic [31:0] Dispatch_Jmp_Addr;
   logic        Cdb_Flush;
   logic [31:0] Cdb_Branch_Addr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] sb [$];
   logic        pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;

   inst_fetch_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0)) dut (
      .Clk(Clk), .Resetb(Resetb),
      .Icache_Rd(Icache_Rd), .Icache_Addr(Icache_Addr),
      .Icache_Data(Icache_Data), .Icache_Valid(Icache_Valid),
      .Ifq_Inst(Ifq_Inst), .Ifq_Pc_Plus4(Ifq_Pc_Plus4), .Ifq_Empty(Ifq_Empty),
      .Dispatch_Ren(Dispatch_Ren), .Dispatch_Jmp(Dispatch_Jmp), .Dispatch_Jmp_Addr(Dispatch_Jmp_Addr),
      .Cdb_Flush(Cdb_Flush), .Cdb_Branch_Addr(Cdb_Branch_Addr)
   );

   always #5 Clk = ~Clk;

   // I-cache responder: answers every request exactly one cycle later with the word index.
   always @(posedge Clk) begin
      logic        r;
      logic [31:0] a;
      r = Icache_Rd;
      a = Icache_Addr;
      #1;
      Icache_Valid = r;
      Icache_Data  = a >> 2;
   end

   // Scoreboard: push accepted returns, pop on dispatch, clear on reset or redirect.
   always @(posedge Clk) begin
      logic redir;
      if (!Resetb) begin
         sb.delete();
         pend = 1'b0;
      end else begin
         redir = Cdb_Flush || (Dispatch_Jmp && Dispatch_Ren && sb.size() != 0);
         if (redir) begin
            sb.delete();
         end else begin
            if (Dispatch_Ren && sb.size() != 0)
               void'(sb.pop_front());
            if (Icache_Valid && pend)
               sb.push_back({Icache_Data, pend_addr + 32'd4});
         end
         pend      = Icache_Rd;
         pend_addr = Icache_Addr;
      end
   end

   task automatic apply_reset();
      Dispatch_Ren      = 1'b0;
      Dispatch_Jmp      = 1'b0;
      Dispatch_Jmp_Addr = 32'h0;
      Cdb_Flush         = 1'b0;
      Cdb_Branch_Addr   = 32'h0;
      Resetb            = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (Icache_Rd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd: got %b expected 0", Icache_Rd); end
      n_checks++; if (Ifq_Empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", Ifq_Empty); end
      n_checks++; if (Ifq_Inst !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_inst: got %h expected 0", Ifq_Inst); end
      n_checks++; if (Ifq_Pc_Plus4 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc4: got %h expected 0", Ifq_Pc_Plus4); end
      n_checks++; if (Icache_Addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 0", Icache_Addr); end
   endtask

   task automatic test_fill();
      apply_reset();
      Resetb = 1'b1;
      #1;
      n_checks++; if (Icache_Rd !== 1'b1 || Icache_Addr !== 32'h0) begin n_fail++; $display("[TB] FAIL fill_req0: got rd=%b addr=%h expected rd=1 addr=0", Icache_Rd, Icache_Addr); end
      for (int i = 1; i < 8; i++) begin
         @(negedge Clk);
         n_checks++; if (Icache_Rd !== (i < 4)) begin n_fail++; $display("[TB] FAIL fill_rd%0d: got %b expected %b", i, Icache_Rd, (i < 4)); end
         if (i < 4) begin
            n_checks++; if (Icache_Addr !== 32'(4 * i)) begin n_fail++; $display("[TB] FAIL fill_addr%0d: got %h expected %h", i, Icache_Addr, 4 * i); end
         end
      end
      n_checks++; if (Ifq_Empty !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_empty: got %b expected 0", Ifq_Empty); end
      n_checks++; if (Ifq_Inst !== 32'h0) begin n_fail++; $display("[TB] FAIL fill_inst: got %h expected 0", Ifq_Inst); end
      n_checks++; if (Ifq_Pc_Plus4 !== 32'h4) begin n_fail++; $display("[TB] FAIL fill_pc4: got %h expected 4", Ifq_Pc_Plus4); end
   endtask

   task automatic test_stream();
      apply_reset();
      Dispatch_Ren = 1'b1;
      Resetb = 1'b1;
      #1;
      n_checks++; if (Ifq_Empty !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_empty_c0: got %b expected 1", Ifq_Empty); end
      @(negedge Clk);
      n_checks++; if (Ifq_Empty !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_empty_c1: got %b expected 1", Ifq_Empty); end
      for (int k = 2; k < 22; k++) begin
         @(negedge Clk);
         n_checks++; if (Ifq_Empty !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_empty_c%0d: got %b expected 0", k, Ifq_Empty); end
         n_checks++; if (Ifq_Inst !== 32'(k - 2)) begin n_fail++; $display("[TB] FAIL stream_inst_c%0d: got %h expected %h", k, Ifq_Inst, k - 2); end
         n_checks++; if (Ifq_Pc_Plus4 !== 32'(4 * (k - 2) + 4)) begin n_fail++; $display("[TB] FAIL stream_pc4_c%0d: got %h expected %h", k, Ifq_Pc_Plus4, 4 * (k - 2) + 4); end
         n_checks++;
         if (sb.size() == 0) begin n_fail++; $display("[TB] FAIL stream_sb_c%0d: got %h_%h expected an entry, scoreboard empty", k, Ifq_Inst, Ifq_Pc_Plus4); end
         else if ({Ifq_Inst, Ifq_Pc_Plus4} !== sb[0]) begin n_fail++; $display("[TB] FAIL stream_sb_c%0d: got %h_%h expected %h", k, Ifq_Inst, Ifq_Pc_Plus4, sb[0]); end
      end
      Dispatch_Ren = 1'b0;
   endtask

   task automatic test_full_pop();
      apply_reset();
      Resetb = 1'b1;
      repeat (8) @(negedge Clk);
      Dispatch_Ren = 1'b1;
      #1;
      n_checks++; if (Icache_Rd !== 1'b0) begin n_fail++; $display("[TB] FAIL fullpop_rd_full: got %b expected 0", Icache_Rd); end
      @(negedge Clk);
      Dispatch_Ren = 1'b0;
      #1;
      n_checks++; if (Icache_Rd !== 1'b1 || Icache_Addr !== 32'h10) begin n_fail++; $display("[TB] FAIL fullpop_req: got rd=%b addr=%h expected rd=1 addr=10", Icache_Rd, Icache_Addr); end
      n_checks++; if (Ifq_Inst !== 32'h1 || Ifq_Pc_Plus4 !== 32'h8) begin n_fail++; $display("[TB] FAIL fullpop_head: got %h/%h expected 1/8", Ifq_Inst, Ifq_Pc_Plus4); end
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         n_checks++; if (Icache_Rd !== 1'b0) begin n_fail++; $display("[TB] FAIL fullpop_norq%0d: got %b expected 0", i, Icache_Rd); end
         n_checks++; if (Ifq_Inst !== 32'h1) begin n_fail++; $display("[TB] FAIL fullpop_hold%0d: got %h expected 1", i, Ifq_Inst); end
      end
   endtask

   task automatic test_jump();
      apply_reset();
      Dispatch_Ren = 1'b1;
      Resetb = 1'b1;
      repeat (4) @(negedge Clk);
      n_checks++; if (Ifq_Inst !== 32'h2 || Ifq_Pc_Plus4 !== 32'hC) begin n_fail++; $display("[TB] FAIL jump_head: got %h/%h expected 2/c", Ifq_Inst, Ifq_Pc_Plus4); end
      Dispatch_Jmp      = 1'b1;
      Dispatch_Jmp_Addr = 32'h100;
      #1;
      n_checks++; if (Icache_Rd !== 1'b0) begin n_fail++; $display("[TB] FAIL jump_rd: got %b expected 0", Icache_Rd); end
      @(negedge Clk);
      Dispatch_Jmp = 1'b0;
      Dispatch_Ren = 1'b0;
      #1;
      n_checks++; if (Icache_Rd !== 1'b1 || Icache_Addr !== 32'h100) begin n_fail++; $display("[TB] FAIL jump_target: got rd=%b addr=%h expected rd=1 addr=100", Icache_Rd, Icache_Addr); end
      n_checks++; if (Ifq_Empty !== 1'b1) begin n_fail++; $display("[TB] FAIL jump_flushed: got %b expected 1", Ifq_Empty); end
      @(negedge Clk);
      n_checks++; if (Ifq_Empty !== 1'b1) begin n_fail++; $display("[TB] FAIL jump_dropped: got %b expected 1", Ifq_Empty); end
      @(negedge Clk);
      n_checks++; if (Ifq_Inst !== 32'h40 || Ifq_Pc_Plus4 !== 32'h104) begin n_fail++; $display("[TB] FAIL jump_newhead: got %h/%h expected 40/104", Ifq_Inst, Ifq_Pc_Plus4); end
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("[TB] FAIL jump_sb: got %h_%h expected an entry, scoreboard empty", Ifq_Inst, Ifq_Pc_Plus4); end
      else if ({Ifq_Inst, Ifq_Pc_Plus4} !== sb[0]) begin n_fail++; $display("[TB] FAIL jump_sb: got %h_%h expected %h", Ifq_Inst, Ifq_Pc_Plus4, sb[0]); end
   endtask

   task automatic test_flush_priority();
      apply_reset();
      Resetb = 1'b1;
      repeat (8) @(negedge Clk);
      Dispatch_Ren      = 1'b1;
      Dispatch_Jmp      = 1'b1;
      Dispatch_Jmp_Addr = 32'h100;
      Cdb_Flush         = 1'b1;
      Cdb_Branch_Addr   = 32'h200;
      #1;
      n_checks++; if (Icache_Rd !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_rd: got %b expected 0", Icache_Rd); end
      @(negedge Clk);
      Dispatch_Ren = 1'b0;
      Dispatch_Jmp = 1'b0;
      Cdb_Flush    = 1'b0;
      #1;
      n_checks++; if (Ifq_Empty !== 1'b1 || Ifq_Inst !== 32'h0) begin n_fail++; $display("[TB] FAIL flush_empty: got empty=%b inst=%h expected 1/0", Ifq_Empty, Ifq_Inst); end
      n_checks++; if (Icache_Rd !== 1'b1 || Icache_Addr !== 32'h200) begin n_fail++; $display("[TB] FAIL flush_pc: got rd=%b addr=%h expected rd=1 addr=200", Icache_Rd, Icache_Addr); end
      @(negedge Clk);
      n_checks++; if (Ifq_Empty !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_still_empty: got %b expected 1", Ifq_Empty); end
      @(negedge Clk);
      n_checks++; if (Ifq_Inst !== 32'h80 || Ifq_Pc_Plus4 !== 32'h204) begin n_fail++; $display("[TB] FAIL flush_newhead: got %h/%h expected 80/204", Ifq_Inst, Ifq_Pc_Plus4); end
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("[TB] FAIL flush_sb: got %h_%h expected an entry, scoreboard empty", Ifq_Inst, Ifq_Pc_Plus4); end
      else if ({Ifq_Inst, Ifq_Pc_Plus4} !== sb[0]) begin n_fail++; $display("[TB] FAIL flush_sb: got %h_%h expected %h", Ifq_Inst, Ifq_Pc_Plus4, sb[0]); end
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      Dispatch_Ren = 1'b1;
      Resetb = 1'b1;
      repeat (5) @(negedge Clk);
      Resetb = 1'b0;
      @(negedge Clk);
      n_checks++; if (Ifq_Empty !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_empty: got %b expected 1", Ifq_Empty); end
      n_checks++; if (Icache_Rd !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rd: got %b expected 0", Icache_Rd); end
      Resetb = 1'b1;
      #1;
      n_checks++; if (Icache_Rd !== 1'b1 || Icache_Addr !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_pc: got rd=%b addr=%h expected rd=1 addr=0", Icache_Rd, Icache_Addr); end
      @(negedge Clk);
      n_checks++; if (Ifq_Empty !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_lost: got %b expected 1", Ifq_Empty); end
      @(negedge Clk);
      n_checks++; if (Ifq_Empty !== 1'b0 || Ifq_Inst !== 32'h0 || Ifq_Pc_Plus4 !== 32'h4) begin n_fail++; $display("[TB] FAIL midrst_head: got empty=%b %h/%h expected 0 0/4", Ifq_Empty, Ifq_Inst, Ifq_Pc_Plus4); end
      Dispatch_Ren = 1'b0;
   endtask

   initial begin
      Resetb            = 1'b0;
      Dispatch_Ren      = 1'b0;
      Dispatch_Jmp      = 1'b0;
      Dispatch_Jmp_Addr = 32'h0;
      Cdb_Flush         = 1'b0;
      Cdb_Branch_Addr   = 32'h0;
      $display("[TB] starting inst_fetch_queue bench");
      test_reset();
      test_fill();
      test_stream();
      test_full_pop();
      test_jump();
      test_flush_priority();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
